// File: rtl/os_readout_ctrl_pkg.sv
// Shared definitions for the output-stationary PSUM readout controller:
// FSM state encoding and the per-mode row counts.
package os_readout_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  localparam int ONIJ_OS = 8;
  localparam int ONIJ_WS = 16;

endpackage

// File: rtl/os_readout_ctrl_relu_col.sv
// Single-column ReLU: clamps a negative two's-complement partial sum to zero
// when enabled, otherwise passes the field through unchanged.
module relu_col #(
  parameter int psum_bw = 16
) (
  input  logic [psum_bw-1:0] din,
  input  logic               relu_en,
  output logic [psum_bw-1:0] dout
);

  assign dout = (relu_en && din[psum_bw-1]) ? {psum_bw{1'b0}} : din;

endmodule

// File: rtl/os_readout_ctrl.sv
// PSUM SRAM readout controller: streams N rows (8 in OS mode, 16 in WS mode)
// from the PSUM memory to the host, with optional per-column ReLU.
module os_readout_ctrl
  import os_readout_ctrl_pkg::*;
#(
  parameter int psum_bw  = 16,
  parameter int col      = 8,
  parameter int max_onij = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   readout_start,
  input  logic                   is_os,
  input  logic                   relu_en,
  output logic                   CEN_pmem,
  output logic [3:0]             A_pmem,
  input  logic [psum_bw*col-1:0] Q_pmem,
  output logic [psum_bw*col-1:0] readout,
  output logic                   readout_valid,
  output logic                   busy
);

  localparam int CW = $clog2(max_onij + 1);

  state_t                 state_r;
  logic [CW-1:0]          n_r;
  logic [CW-1:0]          row_r;
  logic                   cen_r;
  logic [3:0]             addr_r;
  logic                   valid_r;
  logic                   busy_r;
  logic [CW-1:0]          next_addr_s;
  logic [psum_bw*col-1:0] relu_s;

  // The SRAM address runs two ahead of the row on readout because of the
  // one-cycle read latency.
  assign next_addr_s = row_r + CW'(2);

  // Readout FSM: address issue, row counting and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      n_r     <= CW'(ONIJ_OS);
      row_r   <= {CW{1'b0}};
      cen_r   <= 1'b1;
      addr_r  <= 4'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (readout_start) begin
            state_r <= ST_ISSUE;
            n_r     <= is_os ? CW'(ONIJ_OS) : CW'(ONIJ_WS);
            row_r   <= {CW{1'b0}};
            cen_r   <= 1'b0;
            addr_r  <= 4'd0;
            busy_r  <= 1'b1;
          end else begin
            cen_r   <= 1'b1;
            addr_r  <= 4'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_STREAM;
          row_r   <= {CW{1'b0}};
          valid_r <= 1'b1;
          cen_r   <= 1'b0;
          addr_r  <= 4'd1;
        end
        ST_STREAM: begin
          if (row_r == n_r - CW'(1)) begin
            state_r <= ST_IDLE;
            row_r   <= {CW{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            cen_r   <= 1'b1;
            addr_r  <= 4'd0;
          end else begin
            row_r <= row_r + CW'(1);
            // Stop reading once the last address has been issued.
            if (next_addr_s < n_r) begin
              cen_r  <= 1'b0;
              addr_r <= next_addr_s[3:0];
            end else begin
              cen_r  <= 1'b1;
              addr_r <= 4'd0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          row_r   <= {CW{1'b0}};
          cen_r   <= 1'b1;
          addr_r  <= 4'd0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < col; c++) begin : g_col
    relu_col #(.psum_bw(psum_bw)) u_relu (
      .din     (Q_pmem[c*psum_bw +: psum_bw]),
      .relu_en (relu_en),
      .dout    (relu_s[c*psum_bw +: psum_bw])
    );
  end

  // SRAM data is already stable edge to edge, so gating it keeps row 0 on
  // the bus one edge after the ISSUE cycle.
  assign readout       = valid_r ? relu_s : {(psum_bw*col){1'b0}};
  assign readout_valid = valid_r;
  assign busy          = busy_r;
  assign CEN_pmem      = cen_r;
  assign A_pmem        = addr_r;

endmodule

// File: tb/tb_os_readout_ctrl.sv
// Scoreboard bench for os_readout_ctrl: a timing/data reference model predicts
// bus activity per cycle and queues expected rows; a monitor pops and compares.
module tb_os_readout_ctrl;

  localparam int PB  = 16;
  localparam int COL = 8;
  localparam int W   = PB * COL;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         readout_start = 1'b0;
  logic         is_os = 1'b1;
  logic         relu_en = 1'b0;
  logic         CEN_pmem;
  logic [3:0]   A_pmem;
  logic [W-1:0] Q_pmem = '0;
  logic [W-1:0] readout;
  logic         readout_valid;
  logic         busy;

  logic [W-1:0] mem [0:15];
  logic [W-1:0] sb [$];
  int cyc = 0;
  int cur_e1 = -1000;
  int cur_n = 8;
  int n_checks = 0;
  int n_fail = 0;

  os_readout_ctrl #(.psum_bw(PB), .col(COL), .max_onij(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .readout_start (readout_start),
    .is_os         (is_os),
    .relu_en       (relu_en),
    .CEN_pmem      (CEN_pmem),
    .A_pmem        (A_pmem),
    .Q_pmem        (Q_pmem),
    .readout       (readout),
    .readout_valid (readout_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PSUM SRAM model: data appears after the edge that sampled CEN low.
  always @(posedge clk) if (!CEN_pmem) Q_pmem <= mem[A_pmem];

  function automatic logic [W-1:0] relu_ref(logic [W-1:0] row, logic en);
    logic [W-1:0] r;
    logic [PB-1:0] f;
    for (int c = 0; c < COL; c++) begin
      f = row[c*PB +: PB];
      if (en && $signed(f) < 0) f = '0;
      r[c*PB +: PB] = f;
    end
    return r;
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: derives the expected bus activity from the cycle offset since
  // the accepted start edge and pops expected rows whenever the DUT shows one.
  always @(negedge clk) begin : mon
    int d;
    logic v_exp, b_exp, c_exp;
    logic [3:0] a_exp;
    logic [W-1:0] row_exp;
    d = cyc - cur_e1;
    b_exp = (d >= 0 && d <= cur_n);
    v_exp = (d >= 1 && d <= cur_n);
    c_exp = !(d >= 0 && d <= cur_n - 1);
    a_exp = (d >= 1 && d <= cur_n - 1) ? 4'(d) : 4'd0;
    check("readout_valid", W'(readout_valid), W'(v_exp));
    check("busy", W'(busy), W'(b_exp));
    check("CEN_pmem", W'(CEN_pmem), W'(c_exp));
    check("A_pmem", W'(A_pmem), W'(a_exp));
    if (readout_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_row at cycle %0d: got %h expected no row", cyc, readout);
      end else begin
        row_exp = sb.pop_front();
        check("readout", readout, row_exp);
      end
    end else begin
      check("readout_idle", readout, '0);
    end
  end

  // Called just after a negedge; the pulse is sampled at the next posedge.
  task automatic start_pulse(logic os, logic relu);
    int e;
    e = cyc + 1;
    is_os = os;
    readout_start = 1'b1;
    if (reset && e >= cur_e1 + cur_n + 2) begin
      relu_en = relu;
      cur_e1 = e;
      cur_n = os ? 8 : 16;
      for (int k = 0; k < cur_n; k++) sb.push_back(relu_ref(mem[k], relu));
    end
    @(negedge clk);
    readout_start = 1'b0;
  endtask

  // Returns at the first cycle where a new start would be accepted.
  task automatic wait_done();
    while (cyc < cur_e1 + cur_n + 1) @(negedge clk);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 16; k++)
      for (int c = 0; c < COL; c++) mem[k][c*PB +: PB] = PB'($urandom);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [63:0] pat;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // OS readout, row k holds k+1 in every column
    for (int k = 0; k < 16; k++) mem[k] = {COL{PB'(k + 1)}};
    start_pulse(1'b1, 1'b0);
    wait_done();
    // WS readout started back-to-back
    start_pulse(1'b0, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);

    // ReLU boundary fields
    pat = {16'h7FFF, 16'h0005, 16'h8000, 16'hFFFF};
    mem[0] = {pat, pat};
    mem[1] = {pat[31:0], pat, pat[63:32]};
    start_pulse(1'b1, 1'b1);
    wait_done();
    start_pulse(1'b1, 1'b0);
    wait_done();

    // Start while busy, during row 3, with a mode change that must be ignored
    @(negedge clk);
    start_pulse(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    start_pulse(1'b0, 1'b0);
    wait_done();

    // Reset during row 4
    start_pulse(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    cur_e1 = -1000;
    sb.delete();
    #1;
    check("reset_readout", readout, '0);
    check("reset_valid", W'(readout_valid), W'(1'b0));
    check("reset_busy", W'(busy), W'(1'b0));
    check("reset_CEN", W'(CEN_pmem), W'(1'b1));
    check("reset_A", W'(A_pmem), W'(4'd0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    start_pulse(1'b1, 1'b0);
    wait_done();

    // Randomized transfers with random gaps and spurious starts
    for (int t = 0; t < 20; t++) begin
      fill_random();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_pulse(1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, cur_n)) @(negedge clk);
        start_pulse(1'($urandom), 1'b0);
      end
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", W'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
